// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types, default widths and helpers for the Fetch-stage
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

   // Default field widths and halt encoding
   localparam int               DEF_INSTRUCTION_WIDTH = 32;
   localparam int               DEF_OPCODE_WIDTH      = 5;
   localparam logic [4:0]       DEF_HALT_OPCODE       = 5'b11111;

   // Sequencer states; encodings are visible on state_dbg
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_STALL    = 3'd2,
      ST_REDIRECT = 3'd3,
      ST_FLUSH    = 3'd4,
      ST_HALT     = 3'd5
   } state_t;

   // Opcode sits in the most significant bits of the instruction word
   function automatic logic [DEF_OPCODE_WIDTH-1:0] get_opcode(
      input logic [DEF_INSTRUCTION_WIDTH-1:0] instr
   );
      return instr[DEF_INSTRUCTION_WIDTH-1 -: DEF_OPCODE_WIDTH];
   endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/redirect_latch.sv
`default_nettype none
// ============================================================================
// Module      : redirect_latch
// Description : Holds one deferred branch target while the pipeline is
//               stalled. A new capture overwrites the previous target
//               (youngest branch wins); consume clears the valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module redirect_latch #(
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                capture_i,
   input  logic [PC_WIDTH-1:0] target_i,
   input  logic                consume_i,
   output logic                pending_o,
   output logic [PC_WIDTH-1:0] target_o
);

   logic                pending_q;
   logic [PC_WIDTH-1:0] target_q;

   // Capture takes priority so a fresh branch is never lost to a consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
         target_q  <= '0;
      end else if (capture_i) begin
         pending_q <= 1'b1;
         target_q  <= target_i;
      end else if (consume_i) begin
         pending_q <= 1'b0;
      end
   end

   assign pending_o = pending_q;
   assign target_o  = target_q;

endmodule : redirect_latch
`default_nettype wire

// File: rtl/fetch_control.sv
`default_nettype none
// ============================================================================
// Module      : fetch_control
// Description : Fetch-stage sequencer. Drives Fetch enable / PCSelector /
//               NewPC, arbitrates stalls, branch redirects and halt, and
//               produces the IF/ID flush pulse train. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_control
   import fetch_ctrl_pkg::*;
#(
   parameter int                      PC_WIDTH          = 32,
   parameter int                      INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
   parameter int                      OPCODE_WIDTH      = DEF_OPCODE_WIDTH,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE       = DEF_HALT_OPCODE,
   parameter int                      FLUSH_CYCLES      = 2   // legal 1..15
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stall,
   input  logic                         branch_taken,
   input  logic [PC_WIDTH-1:0]          branch_target,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         enable,
   output logic                         PCSelector,
   output logic [PC_WIDTH-1:0]          NewPC,
   output logic                         flush,
   output logic                         halted,
   output logic [2:0]                   state_dbg
);

   // Counter reload value: REDIRECT itself is the first flush cycle
   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t              state_q;
   logic                enable_q;
   logic                pcsel_q;
   logic [PC_WIDTH-1:0] newpc_q;
   logic                flush_q;
   logic                halted_q;
   logic [3:0]          cnt_q;

   logic [OPCODE_WIDTH-1:0] w_opcode;
   logic                    w_halt_hit;
   logic                    w_capture;
   logic                    w_consume;
   logic                    w_go_redirect;
   logic [PC_WIDTH-1:0]     w_redirect_target;
   logic                    w_pending;
   logic [PC_WIDTH-1:0]     w_pending_target;
   logic                    unused_instr_bits;

   // Use the shared helper when widths match the package defaults
   if (INSTRUCTION_WIDTH == DEF_INSTRUCTION_WIDTH &&
       OPCODE_WIDTH == DEF_OPCODE_WIDTH) begin : g_pkg_opcode
      assign w_opcode = get_opcode(instruction);
   end else begin : g_slice_opcode
      assign w_opcode = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
   end

   assign unused_instr_bits = ^instruction[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0];

   // Halt is only honoured on a right-path instruction (flush low)
   assign w_halt_hit = (w_opcode == HALT_OPCODE) && !flush_q;

   // Branch arbitration: defer under stall, otherwise redirect now
   always_comb begin
      w_capture         = 1'b0;
      w_consume         = 1'b0;
      w_go_redirect     = 1'b0;
      w_redirect_target = branch_target;
      case (state_q)
         ST_RUN: begin
            if (branch_taken) begin
               if (stall) w_capture     = 1'b1;
               else       w_go_redirect = 1'b1;
            end
         end
         ST_STALL: begin
            if (stall) begin
               w_capture = branch_taken;
            end else if (branch_taken) begin
               // Same-cycle branch is younger than anything pending
               w_go_redirect = 1'b1;
               w_consume     = 1'b1;
            end else if (w_pending) begin
               w_go_redirect     = 1'b1;
               w_consume         = 1'b1;
               w_redirect_target = w_pending_target;
            end
         end
         ST_REDIRECT, ST_FLUSH: begin
            w_go_redirect = branch_taken;
         end
         default: begin
         end
      endcase
   end

   redirect_latch #(
      .PC_WIDTH (PC_WIDTH)
   ) u_redirect_latch (
      .clk       (clock),
      .rst_n     (reset),
      .capture_i (w_capture),
      .target_i  (branch_target),
      .consume_i (w_consume),
      .pending_o (w_pending),
      .target_o  (w_pending_target)
   );

   // Sequencer state, flush counter and all registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         enable_q <= 1'b0;
         pcsel_q  <= 1'b0;
         newpc_q  <= '0;
         flush_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else if (w_go_redirect) begin
         state_q  <= ST_REDIRECT;
         enable_q <= 1'b1;
         pcsel_q  <= 1'b1;
         flush_q  <= 1'b1;
         newpc_q  <= w_redirect_target;
         cnt_q    <= CNT_LOAD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_RUN;
                  enable_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_capture) begin
                  // Branch beats halt; it waits out the stall
                  state_q  <= ST_STALL;
                  enable_q <= 1'b0;
               end else if (w_halt_hit) begin
                  state_q  <= ST_HALT;
                  enable_q <= 1'b0;
                  halted_q <= 1'b1;
               end else if (stall) begin
                  state_q  <= ST_STALL;
                  enable_q <= 1'b0;
               end
            end
            ST_STALL: begin
               if (!stall) begin
                  state_q  <= ST_RUN;
                  enable_q <= 1'b1;
               end
            end
            ST_REDIRECT: begin
               pcsel_q <= 1'b0;
               if (cnt_q != 4'd0) begin
                  state_q <= ST_FLUSH;
                  cnt_q   <= cnt_q - 4'd1;
               end else begin
                  state_q <= ST_RUN;
                  flush_q <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_RUN;
                  flush_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_HALT: begin
            end
            default: begin
               state_q  <= ST_IDLE;
               enable_q <= 1'b0;
               pcsel_q  <= 1'b0;
               flush_q  <= 1'b0;
               halted_q <= 1'b0;
               cnt_q    <= '0;
            end
         endcase
      end
   end

   assign enable     = enable_q;
   assign PCSelector = pcsel_q;
   assign NewPC      = newpc_q;
   assign flush      = flush_q;
   assign halted     = halted_q;
   assign state_dbg  = state_q;

endmodule : fetch_control
`default_nettype wire

// File: tb/tb_fetch_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_control
// Description : Directed scoreboard bench for fetch_control. The driver
//               pushes the expected registered outputs for each cycle; a
//               separate monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_control;

   localparam logic [31:0] HALT_INSTR = 32'hF800_0000;

   typedef struct {
      string       name;
      logic [2:0]  st;
      logic        en;
      logic        ps;
      logic        fl;
      logic        h;
      logic [31:0] pc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] instruction = '0;
   logic        enable;
   logic        PCSelector;
   logic [31:0] NewPC;
   logic        flush;
   logic        halted;
   logic [2:0]  state_dbg;

   logic        kick = 1'b0;
   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;

   fetch_control #(
      .PC_WIDTH          (32),
      .INSTRUCTION_WIDTH (32),
      .OPCODE_WIDTH      (5),
      .HALT_OPCODE       (5'b11111),
      .FLUSH_CYCLES      (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instruction   (instruction),
      .enable        (enable),
      .PCSelector    (PCSelector),
      .NewPC         (NewPC),
      .flush         (flush),
      .halted        (halted),
      .state_dbg     (state_dbg)
   );

   always #5 clock = ~clock;

   function automatic void push_exp(input string nm, input logic [2:0] st,
                                    input logic en, input logic ps,
                                    input logic fl, input logic h,
                                    input logic [31:0] pc);
      exp_t e;
      e.name = nm; e.st = st; e.en = en; e.ps = ps;
      e.fl = fl; e.h = h; e.pc = pc;
      sb_q.push_back(e);
   endfunction

   // Drive one cycle at the falling edge; expectation is for after the next rise
   task automatic cyc(input string nm, input logic s, input logic sl,
                      input logic br, input logic [31:0] tgt,
                      input logic [31:0] ins, input logic [2:0] e_st,
                      input logic e_en, input logic e_ps, input logic e_fl,
                      input logic e_h, input logic [31:0] e_pc);
      @(negedge clock);
      reset         = 1'b1;
      start         = s;
      stall         = sl;
      branch_taken  = br;
      branch_target = tgt;
      instruction   = ins;
      push_exp(nm, e_st, e_en, e_ps, e_fl, e_h, e_pc);
   endtask

   // Assert reset mid-cycle: outputs must clear without waiting for a clock
   task automatic do_reset(input string nm);
      @(negedge clock);
      reset = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      branch_target = '0; instruction = '0;
      push_exp({nm, "_async"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      kick = 1'b1;
      #2 kick = 1'b0;
      push_exp({nm, "_hold"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // Monitor: compare after each rising edge, or on a mid-cycle kick
   initial begin
      exp_t e;
      forever begin
         @(posedge clock or posedge kick);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (state_dbg !== e.st || enable !== e.en || PCSelector !== e.ps ||
                flush !== e.fl || halted !== e.h || NewPC !== e.pc) begin
               bad++;
               $display("FAIL %s: got st=%0d en=%b ps=%b fl=%b h=%b pc=%h, want st=%0d en=%b ps=%b fl=%b h=%b pc=%h",
                        e.name, state_dbg, enable, PCSelector, flush, halted, NewPC,
                        e.st, e.en, e.ps, e.fl, e.h, e.pc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      #2;
      push_exp("por_async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      kick = 1'b1;
      #2 kick = 1'b0;
      push_exp("por_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      //   name      s  sl br target   instr       st en ps fl h  NewPC
      cyc("idle0",   0, 0, 0, 32'h0,   32'h0,      0, 0, 0, 0, 0, 32'h0);
      cyc("idle1",   0, 0, 0, 32'h0,   32'h0,      0, 0, 0, 0, 0, 32'h0);
      cyc("start",   1, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'h0);
      cyc("run",     0, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'h0);
      // Single redirect: flush two cycles, 3 -> 4 -> 1
      cyc("br40",    0, 0, 1, 32'h40,  32'h0,      3, 1, 1, 1, 0, 32'h40);
      cyc("fl40",    0, 0, 0, 32'h0,   32'h0,      4, 1, 0, 1, 0, 32'h40);
      cyc("run40",   0, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'h40);
      // Stall four cycles with two deferred branches; youngest wins
      cyc("st1",     0, 1, 0, 32'h0,   32'h0,      2, 0, 0, 0, 0, 32'h40);
      cyc("st2",     0, 1, 1, 32'h80,  32'h0,      2, 0, 0, 0, 0, 32'h40);
      cyc("st3",     0, 1, 1, 32'h90,  32'h0,      2, 0, 0, 0, 0, 32'h40);
      cyc("st4",     0, 1, 0, 32'h0,   32'h0,      2, 0, 0, 0, 0, 32'h40);
      cyc("stdrop",  0, 0, 0, 32'h0,   32'h0,      3, 1, 1, 1, 0, 32'h90);
      cyc("fl90",    0, 0, 0, 32'h0,   32'h0,      4, 1, 0, 1, 0, 32'h90);
      cyc("run90",   0, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'h90);
      // Back-to-back: second branch during FLUSH restarts the train
      cyc("br100",   0, 0, 1, 32'h100, 32'h0,      3, 1, 1, 1, 0, 32'h100);
      cyc("fl100",   0, 0, 0, 32'h0,   32'h0,      4, 1, 0, 1, 0, 32'h100);
      cyc("br200",   0, 0, 1, 32'h200, 32'h0,      3, 1, 1, 1, 0, 32'h200);
      cyc("fl200",   0, 0, 0, 32'h0,   32'h0,      4, 1, 0, 1, 0, 32'h200);
      cyc("run200",  0, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'h200);
      // Branch during REDIRECT; halt opcode on wrong path is ignored
      cyc("br300",   0, 0, 1, 32'h300, 32'h0,      3, 1, 1, 1, 0, 32'h300);
      cyc("br310",   0, 0, 1, 32'h310, HALT_INSTR, 3, 1, 1, 1, 0, 32'h310);
      cyc("hltfl1",  0, 0, 0, 32'h0,   HALT_INSTR, 4, 1, 0, 1, 0, 32'h310);
      cyc("hltfl2",  0, 0, 0, 32'h0,   HALT_INSTR, 1, 1, 0, 0, 0, 32'h310);
      cyc("run310",  0, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'h310);
      // Branch with stall in RUN, then a fresh branch as stall drops
      cyc("brstl",   0, 1, 1, 32'hA0,  32'h0,      2, 0, 0, 0, 0, 32'h310);
      cyc("drpbr",   0, 0, 1, 32'hB0,  32'h0,      3, 1, 1, 1, 0, 32'hB0);
      cyc("flB0",    0, 0, 0, 32'h0,   32'h0,      4, 1, 0, 1, 0, 32'hB0);
      cyc("runB0",   0, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'hB0);
      cyc("stlB",    0, 1, 0, 32'h0,   32'h0,      2, 0, 0, 0, 0, 32'hB0);
      cyc("rlsB",    0, 0, 0, 32'h0,   32'h0,      1, 1, 0, 0, 0, 32'hB0);
      // Halt beats stall; HALT ignores start and branches
      cyc("halt",    0, 1, 0, 32'h0,   HALT_INSTR, 5, 0, 0, 0, 1, 32'hB0);
      cyc("hignore", 1, 0, 1, 32'h500, 32'h0,      5, 0, 0, 0, 1, 32'hB0);
      cyc("hhold",   0, 0, 0, 32'h0,   HALT_INSTR, 5, 0, 0, 0, 1, 32'hB0);
      // Reset out of HALT
      do_reset("rsthalt");
      cyc("rs_start",  1, 0, 0, 32'h0,  32'h0,     1, 1, 0, 0, 0, 32'h0);
      cyc("rs_bst",    0, 1, 1, 32'hC0, 32'h0,     2, 0, 0, 0, 0, 32'h0);
      cyc("rs_st",     0, 1, 0, 32'h0,  32'h0,     2, 0, 0, 0, 0, 32'h0);
      // Reset with a pending redirect; it must not resurface
      do_reset("rststall");
      cyc("rs2_start", 1, 0, 0, 32'h0,  32'h0,     1, 1, 0, 0, 0, 32'h0);
      cyc("rs2_stl",   0, 1, 0, 32'h0,  32'h0,     2, 0, 0, 0, 0, 32'h0);
      cyc("rs2_rls",   0, 0, 0, 32'h0,  32'h0,     1, 1, 0, 0, 0, 32'h0);
      cyc("rs2_br",    0, 0, 1, 32'hD0, 32'h0,     3, 1, 1, 1, 0, 32'hD0);
      cyc("rs2_fl",    0, 0, 0, 32'h0,  32'h0,     4, 1, 0, 1, 0, 32'hD0);
      // Reset during FLUSH
      do_reset("rstflush");
      cyc("rs3_idle",  0, 0, 0, 32'h0,  32'h0,     0, 0, 0, 0, 0, 32'h0);
      cyc("rs3_start", 1, 0, 0, 32'h0,  32'h0,     1, 1, 0, 0, 0, 32'h0);
      cyc("rs3_run",   0, 0, 0, 32'h0,  32'h0,     1, 1, 0, 0, 0, 32'h0);

      @(negedge clock);
      @(negedge clock);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d unchecked entries, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_control
`default_nettype wire
